// File: rtl/display_pkg.sv
// display_pkg: shared constants for the count display driver.
//   - Active-low 7-segment codes {g,f,e,d,c,b,a} for digits, 'U', 'd' and blank.
//   - Conversion FSM state encoding.
//   - Digit-index width for the four-digit scan.
//   - seg_decode(): BCD nibble to segment code.
package display_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_U     = 7'b1000001;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam int DIG_IDX_W = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SHIFT  = 2'd2,
        UPDATE = 2'd3
    } conv_state_t;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd9.sv
// bin2bcd9: sequential double-dabble converter, 9-bit binary to three BCD digits.
//   clk, reset   : clock, asynchronous active-high reset
//   start        : request a conversion (honoured only in IDLE)
//   bin          : binary value, captured in LOAD
//   load         : high during LOAD (caller latches its reference copy here)
//   done         : high during UPDATE; hundreds/tens/ones are valid then
//   hundreds/tens/ones : BCD result
module bin2bcd9
    import display_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [8:0] bin,
    output logic       load,
    output logic       done,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    conv_state_t state, state_nxt;
    logic [3:0]  iter;
    logic [8:0]  shreg;
    logic [11:0] acc;
    logic [11:0] acc_adj;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            iter  <= '0;
            shreg <= '0;
            acc   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                LOAD: begin
                    shreg <= bin;
                    acc   <= '0;
                    iter  <= '0;
                end
                SHIFT: begin
                    // adjust-then-shift; the MSB of the binary word enters the BCD LSB
                    acc   <= {acc_adj[10:0], shreg[8]};
                    shreg <= {shreg[7:0], 1'b0};
                    iter  <= iter + 4'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        acc_adj = acc;
        for (int n = 0; n < 3; n++) begin
            if (acc[n*4 +: 4] >= 4'd5)
                acc_adj[n*4 +: 4] = acc[n*4 +: 4] + 4'd3;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    state_nxt = SHIFT;
            SHIFT:   if (iter == 4'd8) state_nxt = UPDATE;
            UPDATE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign load     = (state == LOAD);
    assign done     = (state == UPDATE);
    assign hundreds = acc[11:8];
    assign tens     = acc[7:4];
    assign ones     = acc[3:0];

endmodule

// File: rtl/count_display_driver.sv
// count_display_driver: shows a 9-bit count and its direction on a four-digit
// multiplexed 7-segment display (digits 2..0 = decimal value, digit 3 = 'U'/'d').
//   SCAN_DIV : clk cycles per digit slot (>= 2)
//   LZB      : 1 = blank leading zeros of hundreds/tens
//   clk, reset : clock, asynchronous active-high reset
//   count    : value to display, 0..511
//   updown   : 1 = up ('U'), 0 = down ('d'), used live
//   seg      : segments {g,f,e,d,c,b,a}, active-low
//   an       : digit anodes, active-low, an[0] rightmost
//   dp       : decimal point, active-low, always off
module count_display_driver
    import display_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter bit LZB      = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] count,
    input  logic       updown,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);

    localparam int DIV_W = $clog2(SCAN_DIV);

    logic [8:0] last;
    logic       load, done;
    logic [3:0] bcd_h, bcd_t, bcd_o;
    logic [3:0] hund, tens, ones;

    bin2bcd9 u_conv (
        .clk      (clk),
        .reset    (reset),
        .start    (count != last),
        .bin      (count),
        .load     (load),
        .done     (done),
        .hundreds (bcd_h),
        .tens     (bcd_t),
        .ones     (bcd_o)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last <= '0;
            hund <= '0;
            tens <= '0;
            ones <= '0;
        end else begin
            if (load)
                last <= count;
            if (done) begin
                hund <= bcd_h;
                tens <= bcd_t;
                ones <= bcd_o;
            end
        end
    end

    // Scan: idx is the digit to show at the next tick; sel is the digit being shown.
    // Showing idx before advancing makes the first slot after reset digit 0.
    logic [DIV_W-1:0]     div;
    logic                 tick;
    logic [DIG_IDX_W-1:0] idx, sel, sel_nxt;
    logic                 active, active_nxt;
    logic [3:0]           nib;
    logic                 blank;
    logic [6:0]           seg_nxt;
    logic [3:0]           an_nxt;

    assign tick = (div == DIV_W'(SCAN_DIV - 1));

    always_comb begin
        sel_nxt    = tick ? idx : sel;
        active_nxt = active | tick;
        nib        = ones;
        blank      = 1'b0;
        case (sel_nxt)
            2'd0: nib = ones;
            2'd1: begin
                nib   = tens;
                blank = LZB && (hund == 4'd0) && (tens == 4'd0);
            end
            2'd2: begin
                nib   = hund;
                blank = LZB && (hund == 4'd0);
            end
            2'd3: nib = 4'd0;
        endcase
        if (!active_nxt)
            seg_nxt = SEG_BLANK;
        else if (sel_nxt == 2'd3)
            seg_nxt = updown ? SEG_U : SEG_D;
        else if (blank)
            seg_nxt = SEG_BLANK;
        else
            seg_nxt = seg_decode(nib);
        an_nxt = active_nxt ? ~(4'b0001 << sel_nxt) : 4'hF;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div    <= '0;
            idx    <= '0;
            sel    <= '0;
            active <= 1'b0;
            seg    <= SEG_BLANK;
            an     <= 4'hF;
        end else begin
            div    <= tick ? '0 : div + DIV_W'(1);
            if (tick)
                idx <= idx + 2'd1;
            sel    <= sel_nxt;
            active <= active_nxt;
            seg    <= seg_nxt;
            an     <= an_nxt;
        end
    end

    assign dp = 1'b1;

endmodule

// File: tb/tb_count_display_driver.sv
module tb_count_display_driver;

    logic       clk = 1'b0;
    logic       reset;
    logic [8:0] count;
    logic       updown;
    logic [6:0] seg_a, seg_b;
    logic [3:0] an_a, an_b;
    logic       dp_a, dp_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // A: blanking on, B: blanking off; inputs shared
    count_display_driver #(.SCAN_DIV(4), .LZB(1'b1)) dut_a (
        .clk(clk), .reset(reset), .count(count), .updown(updown),
        .seg(seg_a), .an(an_a), .dp(dp_a));
    count_display_driver #(.SCAN_DIV(4), .LZB(1'b0)) dut_b (
        .clk(clk), .reset(reset), .count(count), .updown(updown),
        .seg(seg_b), .an(an_b), .dp(dp_b));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] code(input int d);
        case (d)
            0: return 7'b1000000;  1: return 7'b1111001;
            2: return 7'b0100100;  3: return 7'b0110000;
            4: return 7'b0011001;  5: return 7'b0010010;
            6: return 7'b0000010;  7: return 7'b1111000;
            8: return 7'b0000000;  9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int val, input bit ud, input bit lzb,
                                           input logic [3:0] anv);
        int h, t, o;
        h = val / 100;
        t = (val / 10) % 10;
        o = val % 10;
        case (anv)
            4'b1110: return code(o);
            4'b1101: return (lzb && h == 0 && t == 0) ? 7'h7F : code(t);
            4'b1011: return (lzb && h == 0) ? 7'h7F : code(h);
            4'b0111: return ud ? 7'b1000001 : 7'b0100001;
            default: return 7'h7F;
        endcase
    endfunction

    // seg of both instances against the model for the digit each is lighting
    task automatic samp(input string tag, input int val);
        chk({tag, "_a"}, seg_a, exp_seg(val, updown, 1'b1, an_a));
        chk({tag, "_b"}, seg_b, exp_seg(val, updown, 1'b0, an_b));
    endtask

    // j cycles after reset release: an and seg fully predicted
    task automatic samp_rst(input string tag, input int val, input int j);
        logic [3:0] an_exp;
        an_exp = (j < 4) ? 4'hF : ~(4'b0001 << (((j - 4) / 4) % 4));
        chk({tag, "_an"}, an_a, an_exp);
        chk({tag, "_sa"}, seg_a, exp_seg(val, updown, 1'b1, an_exp));
        chk({tag, "_sb"}, seg_b, exp_seg(val, updown, 1'b0, an_exp));
    endtask

    task automatic wait_an(input string tag, input logic [3:0] target);
        for (int i = 0; i < 40; i++) begin
            if (an_a == target) break;
            @(negedge clk);
        end
        chk({tag, "_an"}, an_a, target);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset  = 1'b1;
        count  = 9'd0;
        updown = 1'b1;
        cycles(3);
        chk("rst_seg", seg_a, 7'h7F);
        chk("rst_an", an_a, 4'hF);
        chk("rst_dp", dp_a, 1'b1);
        reset = 1'b0;
        for (int j = 1; j <= 9; j++) begin
            @(negedge clk);
            samp_rst($sformatf("boot%0d", j), 0, j);
        end

        // latency: 0 -> 255, seg shows new digits from cycle N+13
        cycles(10);
        count = 9'd255;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            samp($sformatf("lat%0d", k), (k >= 13) ? 255 : 0);
        end

        // change mid-conversion: 100 -> 200 at N, -> 300 at N+5
        count = 9'd100;
        cycles(20);
        count = 9'd200;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            if (k == 5) begin
                samp("mid5", 100);
                count = 9'd300;
            end else
                samp($sformatf("mid%0d", k), (k >= 25) ? 300 : (k >= 13) ? 200 : 100);
        end

        // full scale
        count  = 9'd511;
        updown = 1'b1;
        cycles(12 + 16);
        wait_an("fs0", 4'b1110); chk("fs0_seg", seg_a, 7'b1111001);
        wait_an("fs1", 4'b1101); chk("fs1_seg", seg_a, 7'b1111001);
        wait_an("fs2", 4'b1011); chk("fs2_seg", seg_a, 7'b0010010);
        wait_an("fs3", 4'b0111); chk("fs3_seg", seg_a, 7'b1000001);

        // leading-zero blanking with 7, down
        count  = 9'd7;
        updown = 1'b0;
        cycles(30);
        wait_an("lz0", 4'b1110);
        chk("lz0_a", seg_a, 7'b1111000); chk("lz0_b", seg_b, 7'b1111000);
        wait_an("lz1", 4'b1101);
        chk("lz1_a", seg_a, 7'b1111111); chk("lz1_b", seg_b, 7'b1000000);
        wait_an("lz2", 4'b1011);
        chk("lz2_a", seg_a, 7'b1111111); chk("lz2_b", seg_b, 7'b1000000);
        wait_an("lz3", 4'b0111);
        chk("lz3_a", seg_a, 7'b0100001); chk("lz3_b", seg_b, 7'b0100001);
        chk("dp", dp_b, 1'b1);

        // reset mid-conversion: 0 -> 400, reset at N+6, release at N+8
        count  = 9'd0;
        updown = 1'b1;
        cycles(20);
        count = 9'd400;
        cycles(6);
        reset = 1'b1;
        #1;
        chk("rmid_seg", seg_a, 7'h7F);
        chk("rmid_an", an_a, 4'hF);
        cycles(2);
        chk("rmid_seg2", seg_b, 7'h7F);
        reset = 1'b0;
        for (int j = 1; j <= 24; j++) begin
            @(negedge clk);
            samp_rst($sformatf("rrel%0d", j), (j >= 13) ? 400 : 0, j);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
